maze_memory: RTL

- Upstream store for the maze-solver datapath: holds the 16x16 wall map plus a visited-mark array.
- Answers the datapath's cell query (newX, newY) combinationally with the blocked bit Din.
- The map is loaded row by row over a valid/ready handshake before a solve starts.
- The solver marks cells as visited so that backtracking never re-enters an explored cell.

---
 rtl/maze_memory_pkg.sv | 11 +
 rtl/maze_row_loader.sv | 78 +++++++
 rtl/maze_memory.sv | 63 ++++++
 3 files changed

// File: rtl/maze_memory_pkg.sv
// Shared definitions for the maze map store: geometry and loader state encoding.
package maze_memory_pkg;
  localparam int AW  = 4;
  localparam int DIM = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;
endpackage

// File: rtl/maze_row_loader.sv
// Row-by-row map loader: FSM, row counter and valid/ready handshake.
//  state    | meaning
//  ST_IDLE  | no map present, waiting for load_start
//  ST_LOAD  | accepting rows 0..DIM-1 over the handshake
//  ST_READY | full map present, queries and marking valid
module maze_row_loader
  import maze_memory_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          row_valid,
  output logic          row_ready,
  output logic          loaded,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_row,
  output logic          o_clr_visited
);

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_row_cnt, w_row_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_row_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_row_cnt <= w_row_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_row_cnt_next = r_row_cnt;
    row_ready      = 1'b0;
    loaded         = 1'b0;
    o_wr_en        = 1'b0;
    o_clr_visited  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_state_next   = ST_LOAD;
          w_row_cnt_next = '0;
          o_clr_visited  = 1'b1;
        end
      end
      ST_LOAD: begin
        row_ready = 1'b1;
        // A restart takes priority over any row offered in the same cycle
        if (load_start) begin
          w_row_cnt_next = '0;
          o_clr_visited  = 1'b1;
        end else if (row_valid) begin
          o_wr_en        = 1'b1;
          w_row_cnt_next = r_row_cnt + 1'b1;
          if (r_row_cnt == {AW{1'b1}})
            w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        loaded = 1'b1;
        if (load_start) begin
          w_state_next   = ST_LOAD;
          w_row_cnt_next = '0;
          o_clr_visited  = 1'b1;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_row_cnt_next = '0;
      end
    endcase
  end

  assign o_wr_row = r_row_cnt;

endmodule

// File: rtl/maze_memory.sv
// Wall map plus visited marks for the maze solver; answers cell queries combinationally.
module maze_memory
  import maze_memory_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load_start,
  input  logic           row_valid,
  input  logic [DIM-1:0] row_data,
  output logic           row_ready,
  output logic           loaded,
  input  logic [AW-1:0]  rd_x,
  input  logic [AW-1:0]  rd_y,
  output logic           din,
  input  logic           mark_en,
  input  logic [AW-1:0]  mark_x,
  input  logic [AW-1:0]  mark_y,
  input  logic           clear_marks
);

  logic [DIM-1:0] r_wall    [DIM];
  logic [DIM-1:0] r_visited [DIM];

  logic          w_wr_en;
  logic [AW-1:0] w_wr_row;
  logic          w_load_clr;
  logic          w_clr_all;

  maze_row_loader u_loader (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .loaded        (loaded),
    .o_wr_en       (w_wr_en),
    .o_wr_row      (w_wr_row),
    .o_clr_visited (w_load_clr)
  );

  // Walls are deliberately not reset; loaded gates every read of them.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_wall[w_wr_row] <= row_data;
  end

  assign w_clr_all = clear_marks | w_load_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++)
        r_visited[i] <= '0;
    end else if (w_clr_all) begin
      for (int i = 0; i < DIM; i++)
        r_visited[i] <= '0;
    end else if (mark_en && loaded) begin
      r_visited[mark_y][mark_x] <= 1'b1;
    end
  end

  assign din = ~loaded | r_wall[rd_y][rd_x] | r_visited[rd_y][rd_x];

endmodule
